// File: rtl/serdes_pkg.sv
// Constants and types shared by the SERDES transmit serializer and the receive decoder.
package serdes_pkg;

    localparam logic [9:0] K28_5_RDP = 10'b1100000101;
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/tx_serializer_if.sv
// Byte handshake and serial line bundle between a byte source and the transmit serializer.
interface tx_serializer_if;

    logic [7:0] dataIn;
    logic       dataValid;
    logic       dataReady;
    logic       SerialOut;
    logic       wordStart;
    logic       commaOut;

    modport master (
        output dataIn,
        output dataValid,
        input  dataReady,
        input  SerialOut,
        input  wordStart,
        input  commaOut
    );

    modport slave (
        input  dataIn,
        input  dataValid,
        output dataReady,
        output SerialOut,
        output wordStart,
        output commaOut
    );

endinterface

// File: rtl/tx_serializer_enc8b10b.sv
// Combinational 8b/10b encoder: 5b/6b then 3b/4b with running disparity; only K28.5 is legal with k=1.
module enc8b10b
    import serdes_pkg::*;
(
    input  logic [7:0] din,
    input  logic       k,
    input  logic       rdIn,
    output logic [9:0] code,
    output logic       rdOut
);

    logic [4:0] w_x;
    logic [2:0] w_y;
    logic [5:0] w_6b_n;
    logic [5:0] w_6b;
    logic [3:0] w_4b_n;
    logic [3:0] w_4b;
    logic       w_unbal6;
    logic       w_unbal4;
    logic       w_rd6;
    logic       w_a7;

    assign w_x = din[4:0];
    assign w_y = din[7:5];

    // Tables hold the RD- form; the RD+ form is the complement for unbalanced codes and D.7 / D.x.3.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        w_6b_n = '0;
        case (w_x)
            5'd0:  w_6b_n = 6'b100111;
            5'd1:  w_6b_n = 6'b011101;
            5'd2:  w_6b_n = 6'b101101;
            5'd3:  w_6b_n = 6'b110001;
            5'd4:  w_6b_n = 6'b110101;
            5'd5:  w_6b_n = 6'b101001;
            5'd6:  w_6b_n = 6'b011001;
            5'd7:  w_6b_n = 6'b111000;
            5'd8:  w_6b_n = 6'b111001;
            5'd9:  w_6b_n = 6'b100101;
            5'd10: w_6b_n = 6'b010101;
            5'd11: w_6b_n = 6'b110100;
            5'd12: w_6b_n = 6'b001101;
            5'd13: w_6b_n = 6'b101100;
            5'd14: w_6b_n = 6'b011100;
            5'd15: w_6b_n = 6'b010111;
            5'd16: w_6b_n = 6'b011011;
            5'd17: w_6b_n = 6'b100011;
            5'd18: w_6b_n = 6'b010011;
            5'd19: w_6b_n = 6'b110010;
            5'd20: w_6b_n = 6'b001011;
            5'd21: w_6b_n = 6'b101010;
            5'd22: w_6b_n = 6'b011010;
            5'd23: w_6b_n = 6'b111010;
            5'd24: w_6b_n = 6'b110011;
            5'd25: w_6b_n = 6'b100110;
            5'd26: w_6b_n = 6'b010110;
            5'd27: w_6b_n = 6'b110110;
            5'd28: w_6b_n = 6'b001110;
            5'd29: w_6b_n = 6'b101110;
            5'd30: w_6b_n = 6'b011110;
            5'd31: w_6b_n = 6'b101011;
        endcase
        w_unbal6 = ($countones(w_6b_n) != 3);
        w_6b     = (rdIn && (w_unbal6 || w_x == 5'd7)) ? ~w_6b_n : w_6b_n;
        w_rd6    = rdIn ^ w_unbal6;

        // A7 avoids a run of five identical bits across the sub-block boundary.
        w_a7 = w_rd6 ? (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14)
                     : (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20);
        w_4b_n = '0;
        case (w_y)
            3'd0: w_4b_n = 4'b1011;
            3'd1: w_4b_n = 4'b1001;
            3'd2: w_4b_n = 4'b0101;
            3'd3: w_4b_n = 4'b1100;
            3'd4: w_4b_n = 4'b1101;
            3'd5: w_4b_n = 4'b1010;
            3'd6: w_4b_n = 4'b0110;
            3'd7: w_4b_n = w_a7 ? 4'b0111 : 4'b1110;
        endcase
        w_unbal4 = ($countones(w_4b_n) != 2);
        w_4b     = (w_rd6 && (w_unbal4 || w_y == 3'd3)) ? ~w_4b_n : w_4b_n;

        if (k) begin
            code  = (rdIn == RD_POS) ? K28_5_RDP : K28_5_RDN;
            rdOut = ~rdIn;
        end else begin
            code  = {w_6b, w_4b};
            rdOut = w_rd6 ^ w_unbal4;
        end
    end

endmodule

// File: rtl/tx_serializer.sv
// Transmit serializer: comma sync burst after reset, then 8b/10b-encoded bytes or idle commas, MSB first.
module tx_serializer
    import serdes_pkg::*;
#(
    parameter int SYNC_COMMAS = 4
) (
    input  logic           clkTX,
    input  logic           reset,
    tx_serializer_if.slave link
);

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COMMAS - 1);

    tx_state_t  r_state;
    tx_state_t  w_state_next;
    logic [9:0] r_shift;
    logic [3:0] r_bit_cnt;
    logic [3:0] r_comma_cnt;
    logic       r_rd;
    logic       r_comma;
    logic       w_load;
    logic       w_ready;
    logic       w_take;
    logic [9:0] w_code;
    logic       w_rd_next;

    assign w_load = (r_bit_cnt == 4'd9);
    assign w_take = w_ready & link.dataValid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clkTX) begin
        if (reset) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == SYNC && w_load && r_comma_cnt == SYNC_LAST) begin
            w_state_next = RUN;
        end
    end

    always_comb begin
        w_ready = (r_state == RUN) && w_load;
    end

    enc8b10b u_enc (
        .din   (link.dataIn),
        .k     (~w_take),
        .rdIn  (r_rd),
        .code  (w_code),
        .rdOut (w_rd_next)
    );

    // Every load carries a code group: the accepted byte, or a comma when none is offered.
    always_ff @(posedge clkTX) begin
        if (reset) begin
            r_shift     <= '0;
            r_bit_cnt   <= 4'd9;
            r_comma_cnt <= '0;
            r_rd        <= RD_POS;
            r_comma     <= 1'b0;
        end else if (w_load) begin
            r_shift   <= w_code;
            r_bit_cnt <= '0;
            r_rd      <= w_rd_next;
            r_comma   <= ~w_take;
            if (r_state == SYNC) begin
                r_comma_cnt <= r_comma_cnt + 4'd1;
            end
        end else begin
            r_shift   <= {r_shift[8:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 4'd1;
        end
    end

    assign link.dataReady = w_ready;
    assign link.SerialOut = r_shift[9];
    assign link.wordStart = (r_bit_cnt == 4'd0);
    assign link.commaOut  = r_comma;

endmodule

// File: tb/tb_tx_serializer.sv
// Self-checking bench for tx_serializer: cycle-count timing model plus a rule-based 8b/10b line decoder.
module tb_tx_serializer;

    localparam int SYNC = 4;

    localparam logic [5:0] TBL6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    localparam logic [3:0] TBL4 [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tx_serializer_if tx_if ();

    tx_serializer #(.SYNC_COMMAS(SYNC)) dut (
        .clkTX (clk),
        .reset (reset),
        .link  (tx_if)
    );

    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    int         edge_n = 0;
    logic       cur_is_comma = 1'b1;
    logic [7:0] cur_byte = '0;
    int         acc_cnt = 0;
    int         acc_edge = 0;
    logic       model_rd = 1'b1;
    logic [9:0] word = '0;
    logic [9:0] last_word = '0;
    int         words_done = 0;
    int         comma_words = 0;
    int         data_words = 0;
    int         run_len = 0;
    logic       last_bit = 1'b0;
    logic       run_bad = 1'b0;
    logic [7:0] dec_byte;
    logic       dec_rd;
    logic       dec_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Decodes one code group under the given RD, flagging any disparity or A7/P7 rule violation.
    function automatic void decode(input logic [9:0] w, input logic rd,
                                   output logic [7:0] b, output logic rd_o, output logic err);
        logic [5:0] s6, key6;
        logic [3:0] s4, key4;
        logic       rd6, need_a7;
        int         x, y, n6, n4;
        s6 = w[9:4];
        s4 = w[3:0];
        err = 1'b0;
        x = -1;
        y = -1;
        n6 = $countones(s6);
        key6 = s6;
        rd6 = rd;
        if (n6 == 4) begin
            if (rd) err = 1'b1;
            rd6 = 1'b1;
        end else if (n6 == 2) begin
            if (!rd) err = 1'b1;
            key6 = ~s6;
            rd6 = 1'b0;
        end else if (n6 == 3) begin
            if (s6 == 6'b000111) begin
                key6 = 6'b111000;
                if (!rd) err = 1'b1;
            end else if (s6 == 6'b111000 && rd) begin
                err = 1'b1;
            end
        end else begin
            err = 1'b1;
        end
        for (int i = 0; i < 32; i++) if (TBL6[i] == key6) x = i;
        if (x < 0) begin err = 1'b1; x = 0; end

        n4 = $countones(s4);
        key4 = s4;
        rd_o = rd6;
        if (n4 == 3) begin
            if (rd6) err = 1'b1;
            rd_o = 1'b1;
        end else if (n4 == 1) begin
            if (!rd6) err = 1'b1;
            key4 = ~s4;
            rd_o = 1'b0;
        end else if (n4 == 2) begin
            if (s4 == 4'b0011) begin
                key4 = 4'b1100;
                if (!rd6) err = 1'b1;
            end else if (s4 == 4'b1100 && rd6) begin
                err = 1'b1;
            end
        end else begin
            err = 1'b1;
        end
        if (key4 == 4'b0111) y = 7;
        else for (int i = 0; i < 8; i++) if (TBL4[i] == key4) y = i;
        if (y < 0) begin err = 1'b1; y = 0; end
        if (y == 7) begin
            need_a7 = rd6 ? (x == 11 || x == 13 || x == 14) : (x == 17 || x == 18 || x == 20);
            if ((key4 == 4'b0111) != need_a7) err = 1'b1;
        end
        b = {3'(y), 5'(x)};
    endfunction

    // Reference timing: edge_n counts post-reset edges; loads fall on every tenth edge.
    always @(posedge clk) begin
        if (reset) begin
            edge_n = 0;
            cur_is_comma = 1'b1;
        end else begin
            if (edge_n % 10 == 0) begin
                if (edge_n >= 10 * SYNC && tx_if.dataValid) begin
                    cur_is_comma = 1'b0;
                    cur_byte = tx_if.dataIn;
                    acc_cnt++;
                    acc_edge = edge_n + 1;
                end else begin
                    cur_is_comma = 1'b1;
                end
            end
            edge_n++;
        end
    end

    always @(negedge clk) begin
        int p;
        if (mon_en) begin
            if (edge_n == 0) begin
                check("rst_serial", tx_if.SerialOut, 1'b0);
                check("rst_ready", tx_if.dataReady, 1'b0);
                check("rst_wordstart", tx_if.wordStart, 1'b0);
                check("rst_comma", tx_if.commaOut, 1'b0);
                model_rd = 1'b1;
                run_bad = 1'b0;
            end else begin
                p = (edge_n - 1) % 10;
                check("wordStart", tx_if.wordStart, p == 0);
                check("dataReady", tx_if.dataReady, (edge_n >= 10 * SYNC) && p == 9);
                check("commaOut", tx_if.commaOut, cur_is_comma);
                word = (p == 0) ? {9'b0, tx_if.SerialOut} : {word[8:0], tx_if.SerialOut};
                if (edge_n == 1) run_len = 1;
                else if (tx_if.SerialOut == last_bit) run_len++;
                else run_len = 1;
                last_bit = tx_if.SerialOut;
                if (run_len > 5) run_bad = 1'b1;
                if (p == 9) begin
                    if (cur_is_comma) begin
                        check("comma_word", word, model_rd ? 10'b1100000101 : 10'b0011111010);
                        model_rd = ~model_rd;
                        comma_words++;
                    end else begin
                        decode(word, model_rd, dec_byte, dec_rd, dec_err);
                        check("data_byte", dec_byte, cur_byte);
                        check("disparity_err", dec_err, 1'b0);
                        model_rd = dec_rd;
                        data_words++;
                    end
                    check("run_length", run_bad, 1'b0);
                    run_bad = 1'b0;
                    last_word = word;
                    words_done++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int want_rd, input bit wait_word);
        bit got = 1'b0;
        int tgt;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            #1;
            if (edge_n >= 10 * SYNC && edge_n % 10 == 0 && (want_rd < 0 || int'(model_rd) == want_rd)) begin
                tx_if.dataIn = b;
                tx_if.dataValid = 1'b1;
                @(posedge clk);
                #1;
                tx_if.dataValid = 1'b0;
                got = 1'b1;
            end
        end
        check("send_slot_found", got, 1'b1);
        if (wait_word) begin
            tgt = words_done + 1;
            for (int t = 0; t < 40 && words_done < tgt; t++) @(negedge clk);
            #1;
            check("send_word_done", words_done >= tgt, 1'b1);
        end
    endtask

    task automatic stream(input logic [7:0] first, input int n, input int gap_after);
        int sent = 0;
        int last = acc_cnt;
        int prev_edge = 0;
        int exp_edge = -1;
        int e;
        int cbase = 0;
        int gap_base = 0;
        bool_dummy: begin end
        @(posedge clk);
        #1;
        tx_if.dataIn = first;
        tx_if.dataValid = 1'b1;
        for (int t = 0; t < n * 10 + 200 && sent < n; t++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != last) begin
                last = acc_cnt;
                if (exp_edge >= 0) begin
                    check("gap_resume_edge", acc_edge, exp_edge);
                    check("gap_commas", comma_words - gap_base, 3);
                    exp_edge = -1;
                end else if (sent > 0) begin
                    check("b2b_interval", acc_edge - prev_edge, 10);
                end else begin
                    cbase = comma_words;
                end
                prev_edge = acc_edge;
                sent++;
                tx_if.dataIn = tx_if.dataIn + 8'd1;
                if (sent == gap_after) begin
                    for (int k = 0; k < 10 && edge_n % 10 != 9; k++) begin
                        @(posedge clk);
                        #1;
                    end
                    e = edge_n;
                    gap_base = comma_words;
                    tx_if.dataValid = 1'b0;
                    repeat (25) @(posedge clk);
                    #1;
                    tx_if.dataValid = 1'b1;
                    exp_edge = e + 32;
                end
            end
        end
        tx_if.dataValid = 1'b0;
        check("stream_sent", sent, n);
        if (gap_after < 0) check("b2b_no_comma", comma_words - cbase, 0);
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        int base_w;
        int base_c;
        int base_d;
        int base_a;
        tx_if.dataIn = '0;
        tx_if.dataValid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle: sync burst then alternating fill commas.
        repeat (75) @(posedge clk);
        #1;
        check("idle_comma_words", comma_words, 7);
        check("idle_data_words", data_words, 0);

        send(8'h00, 0, 1'b1);
        check("D0.0_word", last_word, 10'b1001110100);
        check("D0.0_rd", model_rd, 1'b0);
        send(8'hB5, 0, 1'b1);
        check("D21.5_word", last_word, 10'b1010101010);
        check("D21.5_rd", model_rd, 1'b0);
        send(8'hF1, 0, 1'b1);
        check("D17.7_word", last_word, 10'b1000110111);
        check("D17.7_rd", model_rd, 1'b1);
        send(8'hEB, 1, 1'b1);
        check("D11.7_word", last_word, 10'b1101001000);
        check("D11.7_rd", model_rd, 1'b0);

        stream(8'h00, 256, -1);
        stream(8'h40, 30, 12);

        // Random bytes with random valid duty; the line model checks every word.
        base_d = data_words;
        base_a = acc_cnt;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            tx_if.dataValid = ($urandom_range(0, 3) != 0);
            tx_if.dataIn = 8'($urandom);
        end
        tx_if.dataValid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("rand_words_decoded", data_words - base_d, acc_cnt - base_a);

        // Reset while bit 4 of a data word is on the line.
        send(8'h5A, -1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        base_w = words_done;
        base_c = comma_words;
        for (int t = 0; t < 20 && words_done == base_w; t++) @(negedge clk);
        #1;
        check("rst_first_word", last_word, 10'b1100000101);
        for (int t = 0; t < 60 && edge_n < 41; t++) begin
            @(posedge clk);
            #1;
        end
        check("rst_sync_commas", comma_words - base_c, SYNC);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tx_serializer.md
# tx_serializer

Transmit end of the SERDES link. Accepts bytes over a valid/ready handshake, 8b/10b-encodes them with running-disparity tracking, and shifts each 10-bit code group out one bit per `clkTX` cycle. After reset it sends a burst of K28.5 commas so the receiver can find word alignment. It also fills idle slots with commas.

## Interface
- `SYNC_COMMAS`, default 4: number of K28.5 code groups sent after reset before any data is accepted; legal range 1–15.
- `clkTX`  in  1  transmit clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dataIn`  in  8  byte to send; bit 7 = H, bit 0 = A.
- `dataValid`  in  1  `dataIn` holds a byte to send.
- `dataReady`  out  1  the block takes `dataIn` on this edge if `dataValid`.
- `SerialOut`  out  1  serial line.
- `wordStart`  out  1  high while `SerialOut` carries bit 9 of a code group.
- `commaOut`  out  1  high for all 10 bits of a comma code group.

## Operation
- **Code group format:** 10-bit `abcdei fghj`, packed with `a` = bit 9 and `j` = bit 0; bit 9 is shifted out first.
- **Running disparity (`rd`):** 0 = RD−, 1 = RD+. Updated every time a code group is loaded, using the RD output of the encoder.
- **Comma values:**
  - K28.5 with `rd`=1 is 1100000101, leaving `rd`=0.
  - K28.5 with `rd`=0 is 0011111010, leaving `rd`=1.
- **Reset values:**
  - shift register = 0, so `SerialOut`=0
  - `bitCnt`=9, `rd`=1, `state`=SYNC, `commaCnt`=0
  - `dataReady`=0, `wordStart`=0, `commaOut`=0
- **Load point:** the cycle in which `bitCnt`==9. On that edge the next code group goes into the shift register, `bitCnt` goes to 0, and `rd` is updated. On all other edges the register shifts left by one and `bitCnt` increments.
- **FSM:**
  - SYNC: every load is a comma and `commaCnt` increments. When the load that brings `commaCnt` to `SYNC_COMMAS` happens, go to RUN.
  - RUN: at a load, if `dataValid` is high, load the encoded `dataIn`; otherwise load a comma. RUN persists until `reset`.
- **Handshake:**
  - `dataReady` = (`state`==RUN) & (`bitCnt`==9), combinational from registers; it does not depend on `dataValid`.
  - A byte is consumed only on an edge where both `dataValid` and `dataReady` are high.
  - `dataIn` must be stable only in that cycle.
  - `dataValid` high in any other cycle has no effect.
- **Encoder rules:**
  - Standard 5b/6b and 3b/4b tables, with disparity chosen from the current `rd`.
  - The 3b/4b stage uses the disparity after the 6b sub-block.
  - D.x.7 uses the A7 code for x=17, 18, 20 when RD− and for x=11, 13, 14 when RD+.
  - Neutral sub-blocks leave RD unchanged.
- **Reset mid-word:** the partial word is abandoned. The line is held at 0 while `reset` is high, then a fresh SYNC burst starts at RD+.

## Timing
- **Start-up:** bit 9 of the first comma appears on `SerialOut` in the first cycle after `reset` deasserts.
- **Throughput:** one code group every 10 cycles, with no gap between groups.
- **Latency:** bit 9 of an accepted byte's code group is on `SerialOut` the cycle after the accepting edge; bit 0 appears 9 cycles after that.
- **Output alignment:**
  - `wordStart` = (`bitCnt`==0).
  - `commaOut` is a registered flag set at each load; it is valid for the same 10 cycles as the code group it labels.
- **Minimum wait:** the first `dataReady` pulse occurs SYNC_COMMAS×10 cycles after the first post-reset edge, i.e. during the last bit of the final sync comma.

## Structure
- **Shared package `serdes_pkg`:**
  - `K28_5_RDP` = 10'b1100000101 and `K28_5_RDN` = 10'b0011111010
  - `RD_NEG`=0, `RD_POS`=1
  - state encodings SYNC and RUN
  - the shared package is also used by the receiver's decoder.
- **Sub-module `enc8b10b`:** purely combinational, ports (`din[7:0]`, `k`, `rdIn`, `code[9:0]`, `rdOut`). Only K28.5 is legal with `k`=1. It is unit-testable against the decoder.
- **Top level:** holds the FSM, `bitCnt`, `commaCnt`, the 10-bit shift register, and the `rd` register.

## Test plan
- **Idle after reset:** reset, then hold `dataValid`=0.
  - `SerialOut` carries 1100000101, 0011111010, 1100000101, 0011111010, and keeps alternating.
  - `commaOut`=1 throughout.
  - `dataReady` stays 0 for the first 40 cycles, then pulses once every 10 cycles.
- **D.0.0 then D.21.5:** after sync (`rd`=0), send 0x00 then 0xB5.
  - Words out are 1001110100 then 1010101010.
  - `rd` stays 0 after each word.
- **A7 rule:** with `rd`=0, send 0xF1 (D.17.7).
  - Word out is 1000110111 and `rd` becomes 1.
  - Then send 0xEB (D.11.7): word out is 1101001000 and `rd` becomes 0.
- **Back-to-back throughput:** hold `dataValid`=1 with an incrementing byte for 256 words.
  - Exactly one byte is accepted every 10 cycles.
  - No comma is inserted.
  - Decoding the line through the receiver gives 0x00..0xFF with no disparity errors.
- **Idle gap:** drop `dataValid` for 25 cycles in the middle of a stream.
  - Exactly the next 3 load points carry commas, matching the current `rd`.
  - The data byte presented afterwards is accepted at the next `dataReady`.
- **Reset mid-word:** assert `reset` at bit 4 of a data word and hold it for 3 cycles.
  - `SerialOut`=0 during reset.
  - After release, `SerialOut` carries 1100000101 first, and 4 sync commas are sent before `dataReady` rises.
